lane_arb_mux: RTL

- Multi-channel successor to the single-lane `subcomponent` receive/transmit block.
- Accepts `NUM_CH` independent receive lanes of `DATA_W` bits. Each lane buffers into its own `DEPTH`-entry FIFO.
- A fair round-robin arbiter merges the lanes onto one registered transmit lane with a valid/ready handshake, tagged with the source channel.
- Sits between per-lane receivers and a shared downstream consumer inside the `top*` wrappers.

---
 rtl/lane_arb_mux.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/lane_arb_mux.sv
// lane_arb_mux: merges NUM_CH receive lanes onto one registered transmit lane.
// Each lane buffers into its own DEPTH-entry FIFO. A round-robin arbiter pops
// one head word per load cycle into the output register, tagged with its lane.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   enable        gates new writes (buffered words still drain)
//   data_rx       NUM_CH packed lanes, lane i at [i*DATA_W +: DATA_W]
//   data_rx_vld   per-lane valid
//   data_rx_rdy   per-lane ready (enable && !fifo_full, low in reset)
//   data_tx       merged output word (registered)
//   data_tx_ch    source lane of data_tx (registered)
//   data_tx_vld   output valid (registered)
//   data_tx_rdy   downstream ready
//   fifo_full     per-lane FIFO full flag (registered)
//   data_tx_par   even parity of data_tx, only with LANE_ARB_MUX_PARITY_EN
//
// Optional feature macro: LANE_ARB_MUX_PARITY_EN

module lane_arb_mux #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned DATA_W = 10,
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [NUM_CH*DATA_W-1:0] data_rx,
   input  logic [NUM_CH-1:0]        data_rx_vld,
   output logic [NUM_CH-1:0]        data_rx_rdy,
   output logic [DATA_W-1:0]        data_tx,
   output logic [CH_W-1:0]          data_tx_ch,
   output logic                     data_tx_vld,
   input  logic                     data_tx_rdy,
   output logic [NUM_CH-1:0]        fifo_full
`ifdef LANE_ARB_MUX_PARITY_EN
   ,
   output logic                     data_tx_par
`endif
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = AW + 1;

   logic [DATA_W-1:0] mem_q  [NUM_CH][DEPTH];
   logic [DATA_W-1:0] head_c [NUM_CH];

   logic [PTR_W-1:0]  wptr_q [NUM_CH];
   logic [PTR_W-1:0]  wptr_d [NUM_CH];
   logic [PTR_W-1:0]  rptr_q [NUM_CH];
   logic [PTR_W-1:0]  rptr_d [NUM_CH];
   logic [PTR_W-1:0]  cnt_q  [NUM_CH];
   logic [PTR_W-1:0]  cnt_d  [NUM_CH];

   logic [NUM_CH-1:0] full_q, full_d;
   logic [NUM_CH-1:0] nonempty_c, wr_c, pop_c;

   logic [CH_W-1:0]   last_q, last_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [CH_W-1:0]   tx_ch_q, tx_ch_d;
   logic              tx_vld_q, tx_vld_d;
   logic              load_c;

   // Pointer increment wrapping modulo DEPTH.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Ready depends only on registered full state, enable and reset.
   assign data_rx_rdy = {NUM_CH{rst_n & enable}} & ~full_q;

   // Per-lane status and head-of-FIFO words.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         nonempty_c[i] = (cnt_q[i] != '0);
         wr_c[i]       = data_rx_vld[i] & rst_n & enable & ~full_q[i];
         head_c[i]     = mem_q[i][rptr_q[i][AW-1:0]];
      end
   end

   // Round-robin grant starting after the last served lane; pops into the output register.
   always_comb begin
      logic found;
      found    = 1'b0;
      load_c   = ~tx_vld_q | data_tx_rdy;
      pop_c    = '0;
      last_d   = last_q;
      tx_d     = tx_q;
      tx_ch_d  = tx_ch_q;
      tx_vld_d = tx_vld_q;
      if (load_c) begin
         tx_vld_d = |nonempty_c;
         for (int k = 1; k <= NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (!found && nonempty_c[i] &&
                   (((int'(last_q) + k) % int'(NUM_CH)) == i)) begin
                  found    = 1'b1;
                  pop_c[i] = 1'b1;
                  last_d   = CH_W'(i);
                  tx_d     = head_c[i];
                  tx_ch_d  = CH_W'(i);
               end
            end
         end
      end
   end

   // FIFO pointer/count next state; full flag follows the next count.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         wptr_d[i] = wptr_q[i];
         rptr_d[i] = rptr_q[i];
         cnt_d[i]  = cnt_q[i];
         if (wr_c[i]) begin
            wptr_d[i] = ptr_inc(wptr_q[i]);
         end
         if (pop_c[i]) begin
            rptr_d[i] = ptr_inc(rptr_q[i]);
         end
         case ({wr_c[i], pop_c[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + PTR_W'(1);
            2'b01:   cnt_d[i] = cnt_q[i] - PTR_W'(1);
            default: cnt_d[i] = cnt_q[i];
         endcase
         full_d[i] = (cnt_d[i] == PTR_W'(DEPTH));
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wptr_q[i] <= '0;
            rptr_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         full_q   <= '0;
         last_q   <= CH_W'(NUM_CH - 1);
         tx_q     <= '0;
         tx_ch_q  <= '0;
         tx_vld_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            wptr_q[i] <= wptr_d[i];
            rptr_q[i] <= rptr_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         full_q   <= full_d;
         last_q   <= last_d;
         tx_q     <= tx_d;
         tx_ch_q  <= tx_ch_d;
         tx_vld_q <= tx_vld_d;
      end
   end

   // FIFO storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_c[i]) begin
            mem_q[i][wptr_q[i][AW-1:0]] <= data_rx[i*DATA_W +: DATA_W];
         end
      end
   end

   assign data_tx     = tx_q;
   assign data_tx_ch  = tx_ch_q;
   assign data_tx_vld = tx_vld_q;
   assign fifo_full   = full_q;

`ifdef LANE_ARB_MUX_PARITY_EN
   logic par_q;

   // Parity tracks the next data_tx value, so it loads and holds with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= ^tx_d;
      end
   end

   assign data_tx_par = par_q;
`endif

endmodule
